uart_rxd: RTL and testbench

- Serial receive stage paired with the LC3 UART transmitter; deserialises 8N1 / 8-bit-plus-parity frames from the `rxd` pin.
- Presents the byte as a 16-bit memory-mapped data word with a ready flag, which the LC3 keyboard/serial status/data registers consume.
- Parity configuration matches the transmitter's run-time `parity_en` / `parity_kind` inputs, so one register drives both directions.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_baud.sv | 38 +++
 rtl/uart_rxd.sv | 176 +++++++++++++++++
 tb/tb_uart_rxd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Purpose: FSM state encoding shared by the UART transmitter and receiver,
//          parity-kind encodings and the default bit-period divisor.
// Ports:   none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

    // 9600 bps from the system clock
    localparam int unsigned DEFAULT_CLK_DIV = 32'h0000_28B0;

endpackage

// File: rtl/uart_rx_baud.sv
// rtl/uart_rx_baud.sv - bit-period counter for the UART receiver
// Purpose: counts clk from a clear; flags the half-bit and full-bit sample
//          points (shifted later by TICK_OFS clk when samples are voted).
// Ports:   clk, rst       - clock, synchronous active-high reset
//          clr            - zero the count on the next edge
//          en             - count enable
//          half_tick      - count is at the half-bit sample point
//          full_tick      - count is at the full-bit sample point
module uart_rx_baud #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned HALF_DIV = CLK_DIV / 2,
    parameter int unsigned TICK_OFS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [15:0] HALF_PT = 16'(HALF_DIV - 1 + TICK_OFS);
    localparam logic [15:0] FULL_PT = 16'(CLK_DIV - 1 + TICK_OFS);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 16'd0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign half_tick = en && (cnt == HALF_PT);
    assign full_tick = en && (cnt == FULL_PT);

endmodule

// File: rtl/uart_rxd.sv
// rtl/uart_rxd.sv - UART serial receiver (8 data bits, optional parity)
// Purpose: deserialises frames from rxd into a 16-bit data word with a ready
//          flag and sticky parity / framing / overrun flags.
// Macro:   UART_RX_MAJORITY_EN - 2-of-3 voted samples and 2-clk start-edge
//          qualification; undefined gives single-point sampling.
// Ports:   clk, rst                - clock, synchronous active-high reset
//          rxd                     - asynchronous serial input, idle high
//          parity_en, parity_kind  - parity enable, 1 = odd / 0 = even
//          rd_ack                  - CPU read strobe for the data register
//          rx_data                 - {8'h00, received byte}
//          rx_ready                - unread byte held in rx_data
//          parity_err, frame_err   - sticky error flags of the last byte
//          overrun                 - sticky, a byte was dropped
//          busy                    - receiver is inside a frame
module uart_rxd
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int unsigned HALF_DIV = CLK_DIV / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    uart_state_t state, state_n;

    logic       sync1, rxs, rxs_q;
    logic       fall, sample, tick, done;
    logic       half_tick, full_tick;
    logic [7:0] shreg, rx_byte;
    logic [2:0] bit_idx;
    logic       p_en, p_kind, perr_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned TICK_OFS = 1;
    logic rxs_qq;

    always_ff @(posedge clk) begin
        if (rst) rxs_qq <= 1'b1;
        else     rxs_qq <= rxs_q;
    end

    // Decision taken one clk after the nominal point: rxs_qq/rxs_q/rxs hold
    // the line at point-1, point and point+1.
    assign fall   = rxs_qq && !rxs_q && !rxs;
    assign sample = (rxs_qq & rxs_q) | (rxs_qq & rxs) | (rxs_q & rxs);
`else
    localparam int unsigned TICK_OFS = 0;

    assign fall   = rxs_q && !rxs;
    assign sample = rxs;
`endif

    // Counter sits at zero in IDLE and restarts after every sample, so each
    // bit period is measured from the previous sample point.
    uart_rx_baud #(
        .CLK_DIV (CLK_DIV),
        .HALF_DIV(HALF_DIV),
        .TICK_OFS(TICK_OFS)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state == IDLE) || tick),
        .en       (1'b1),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        tick    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_n = START;
            end
            START: begin
                tick = half_tick;
                if (tick) state_n = sample ? IDLE : DATA;
            end
            DATA: begin
                tick = full_tick;
                if (tick && bit_idx == 3'd7) state_n = p_en ? PARITY : STOP;
            end
            PARITY: begin
                tick = full_tick;
                if (tick) state_n = STOP;
            end
            STOP: begin
                tick = full_tick;
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign done = (state == STOP) && tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= 8'h00;
            bit_idx    <= 3'd0;
            p_en       <= 1'b0;
            p_kind     <= 1'b0;
            perr_pend  <= 1'b0;
            rx_byte    <= 8'h00;
            rx_ready   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE && fall) begin
                p_en      <= parity_en;
                p_kind    <= parity_kind;
                perr_pend <= 1'b0;
                bit_idx   <= 3'd0;
            end
            if (state == DATA && tick) begin
                shreg   <= {sample, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == PARITY && tick) begin
                perr_pend <= (sample != (^shreg ^ p_kind));
            end

            // A read in the completion cycle consumes the old byte, so the
            // new one is accepted rather than counted as an overrun.
            if (done) begin
                if (!rx_ready || rd_ack) begin
                    rx_byte    <= shreg;
                    rx_ready   <= 1'b1;
                    parity_err <= perr_pend;
                    frame_err  <= ~sample;
                    if (rd_ack) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack) begin
                rx_ready   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    assign rx_data = {8'h00, rx_byte};
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rxd.sv
// tb/tb_uart_rxd.sv - directed self-checking bench for uart_rxd
module tb_uart_rxd;

    localparam int CLK_DIV = 16;

    logic        clk = 1'b0;
    logic        rst, rxd, parity_en, parity_kind, rd_ack;
    logic [15:0] rx_data;
    logic        rx_ready, parity_err, frame_err, overrun, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_ready && !rdy_prev) rise_cyc = cyc;
        rdy_prev = rx_ready;
    end

    uart_rxd #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .parity_en  (parity_en),
        .parity_kind(parity_kind),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic pbit, input logic stop);
        rxd      = 1'b0;
        fall_cyc = cyc;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CLK_DIV);
        end
        if (use_par) begin
            rxd = pbit;
            tick(CLK_DIV);
        end
        rxd = stop;
        tick(CLK_DIV);
        rxd = 1'b1;
    endtask

    task automatic read_ack();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [15:0] data, input logic rdy,
                             input logic pe, input logic fe, input logic ov);
        @(negedge clk);
        chk({tag, "_data"}, rx_data, data);
        chk({tag, "_rdy"}, rx_ready, rdy);
        chk({tag, "_perr"}, parity_err, pe);
        chk({tag, "_ferr"}, frame_err, fe);
        chk({tag, "_ovr"}, overrun, ov);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; parity_en = 1'b0; parity_kind = 1'b0; rd_ack = 1'b0;
        tick(3);
        chk_flags("reset", 16'h0000, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick(5);

        // 0xA5, 8N1, latency 2+8+9*16+1
        send_frame(8'hA5, 0, 0, 1);
        chk_flags("a5", 16'h00A5, 1, 0, 0, 0);
        chk("a5_lat", rise_cyc - fall_cyc, 155);
        chk("a5_busy", busy, 0);
        read_ack();
        chk_flags("a5_ack", 16'h00A5, 0, 0, 0, 0);

        // 0x03 odd parity, correct then wrong parity bit
        parity_en = 1'b1; parity_kind = 1'b1;
        send_frame(8'h03, 1, 1, 1);
        chk_flags("p_ok", 16'h0003, 1, 0, 0, 0);
        chk("p_lat", rise_cyc - fall_cyc, 171);
        read_ack();
        send_frame(8'h03, 1, 0, 1);
        chk_flags("p_bad", 16'h0003, 1, 1, 0, 0);
        read_ack();
        chk_flags("p_ack", 16'h0003, 0, 0, 0, 0);
        parity_en = 1'b0; parity_kind = 1'b0;
        tick(4);

        // false start: 3 clk low pulse
        rxd = 1'b0;
        fall_cyc = cyc;
        tick(3);
        rxd = 1'b1;
        chk("fs_busy_hi", busy, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("fs_drop", cyc - fall_cyc, 11);
        chk_flags("fs", 16'h0003, 0, 0, 0, 0);
        tick(4);

        // framing error still delivers the byte
        send_frame(8'h5A, 0, 0, 0);
        chk_flags("ferr", 16'h005A, 1, 0, 1, 0);
        read_ack();
        chk_flags("ferr_ack", 16'h005A, 0, 0, 0, 0);
        tick(4);

        // overrun: second byte dropped
        send_frame(8'h11, 0, 0, 1);
        send_frame(8'h22, 0, 0, 1);
        chk_flags("ovr", 16'h0011, 1, 0, 0, 1);
        read_ack();
        chk_flags("ovr_ack", 16'h0011, 0, 0, 0, 0);
        tick(4);

        // read in the completion cycle of 0x22 lets it in
        send_frame(8'h11, 0, 0, 1);
        fork
            send_frame(8'h22, 0, 0, 1);
            begin
                tick(154);
                rd_ack = 1'b1;
                tick(1);
                rd_ack = 1'b0;
            end
        join
        chk_flags("ack_win", 16'h0022, 1, 0, 0, 0);
        tick(4);

        // reset during DATA bit 4 of 0x7E
        rxd = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'(8'h7E >> i);
            tick(CLK_DIV);
        end
        rxd = 1'b1;
        tick(8);
        chk("rst_busy_pre", busy, 1);
        rst = 1'b1;
        tick(1);
        chk("rst_data", rx_data, 16'h0000);
        chk("rst_rdy", rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
        rst = 1'b0;
        tick(40);

        send_frame(8'h81, 0, 0, 1);
        chk_flags("post_rst", 16'h0081, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
